// File: rtl/saturating_counter_table.sv
// Indexed table of DEPTH independent WIDTH-bit saturating counters.
// Define SATURATING_COUNTER_TABLE_FORWARDING_EN to forward same-cycle updates to the read port.
module saturating_counter_table #(
    parameter int WIDTH       = 2,
    parameter int DEPTH       = 16,
    parameter int RESET       = 0,
    parameter int THRESHOLD   = 2 ** (WIDTH - 1),
    parameter int INDEX_WIDTH = $clog2(DEPTH)
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   update_enable,
    input  logic [INDEX_WIDTH-1:0] update_index,
    input  logic                   update_increment,
    input  logic                   update_decrement,
    input  logic                   update_load,
    input  logic [WIDTH-1:0]       update_value,
    input  logic [INDEX_WIDTH-1:0] read_index,
    output logic [WIDTH-1:0]       read_count,
    output logic                   read_above,
    output logic                   read_saturated_max,
    output logic                   read_saturated_min
);

    localparam logic [INDEX_WIDTH:0] DEPTH_W  = DEPTH[INDEX_WIDTH:0];
    localparam logic [WIDTH:0]       THRESH_W = THRESHOLD[WIDTH:0];
    localparam logic [WIDTH-1:0]     RESET_W  = RESET[WIDTH-1:0];
    localparam logic [WIDTH-1:0]     MAX_W    = '1;

    logic [WIDTH-1:0] table_q [DEPTH];
    logic             update_valid;
    logic             read_valid;
    logic [WIDTH-1:0] update_current;
    logic [WIDTH-1:0] update_next;

    // Next value of the addressed entry; saturation checked before add/subtract.
    always_comb begin
        update_valid   = update_enable && ({1'b0, update_index} < DEPTH_W);
        update_current = '0;
        if ({1'b0, update_index} < DEPTH_W) begin
            update_current = table_q[update_index];
        end
        update_next = update_current;
        if (update_load) begin
            update_next = update_value;
        end else if (update_increment && !update_decrement) begin
            if (update_current != MAX_W) begin
                update_next = update_current + 1'b1;
            end
        end else if (update_decrement && !update_increment) begin
            if (update_current != '0) begin
                update_next = update_current - 1'b1;
            end
        end
    end

    // Counter storage: reset loads every entry, otherwise only the target changes.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= RESET_W;
            end
        end else if (update_valid) begin
            table_q[update_index] <= update_next;
        end
    end

    // Combinational read port with status flags derived from the read value.
    always_comb begin
        read_valid = ({1'b0, read_index} < DEPTH_W);
        read_count = '0;
        if (read_valid) begin
            read_count = table_q[read_index];
        end
`ifdef SATURATING_COUNTER_TABLE_FORWARDING_EN
        if (update_valid && (read_index == update_index)) begin
            read_count = update_next;
        end
`endif
        read_above         = ({1'b0, read_count} >= THRESH_W);
        read_saturated_max = (read_count == MAX_W);
        read_saturated_min = (read_count == '0);
    end

endmodule
